baud_generator: RTL and testbench

- Free-running clock-enable generator for the UART.
- Emits a single-cycle `enable` strobe at the oversampled baud rate (BAUD × OVERSAMPLE).
- Emits a single-cycle `bit_tick` strobe once per bit period, every OVERSAMPLE `enable` strobes.
- Sits between the system clock and the UART TX/RX state machines; they advance only on these strobes.

---
 rtl/baud_generator.sv | 81 ++++++++
 tb/tb_baud_generator.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/baud_generator.sv
// Free-running clock-enable generator for the UART: an `enable` strobe every DIV
// clocks and a `bit_tick` strobe on every OVERSAMPLE-th `enable`.
module baud_generator #(
    parameter int CLOCK_HZ   = 100_000_000,
    parameter int BAUD       = 115_200,
    parameter int OVERSAMPLE = 16,
    parameter int DIV        = (CLOCK_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE)
) (
    input  logic clk,
    input  logic rst_n,
    output logic enable,
    output logic bit_tick
);

    localparam int DIV_W = ($clog2(DIV) > 1) ? $clog2(DIV) : 1;
    localparam int OS_W  = ($clog2(OVERSAMPLE) > 1) ? $clog2(OVERSAMPLE) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);

    generate
        if (DIV < 2) begin : g_div_check
            $fatal(1, "baud_generator: DIV must be >= 2");
        end
        if (OVERSAMPLE < 1) begin : g_os_check
            $fatal(1, "baud_generator: OVERSAMPLE must be >= 1");
        end
    endgenerate

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic [OS_W-1:0]  os_q;
    logic [OS_W-1:0]  os_d;
    logic             div_wrap_s;
    logic             os_wrap_s;
    logic             enable_q;
    logic             enable_d;
    logic             bit_tick_q;
    logic             bit_tick_d;

    // Next-state logic: divider wraps at DIV-1, oversample counter steps only on a wrap.
    always_comb begin
        div_wrap_s = (div_q == DIV_LAST);
        os_wrap_s  = (os_q == OS_LAST);
        div_d      = div_q;
        os_d       = os_q;
        if (div_wrap_s) begin
            div_d = {DIV_W{1'b0}};
            if (os_wrap_s) begin
                os_d = {OS_W{1'b0}};
            end else begin
                os_d = os_q + OS_W'(1);
            end
        end else begin
            div_d = div_q + DIV_W'(1);
            os_d  = os_q;
        end
        // Strobes register on the wrapping edge, so they are high in the cycle after it.
        enable_d   = div_wrap_s;
        bit_tick_d = div_wrap_s & os_wrap_s;
    end

    // State and output registers, cleared asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q      <= {DIV_W{1'b0}};
            os_q       <= {OS_W{1'b0}};
            enable_q   <= 1'b0;
            bit_tick_q <= 1'b0;
        end else begin
            div_q      <= div_d;
            os_q       <= os_d;
            enable_q   <= enable_d;
            bit_tick_q <= bit_tick_d;
        end
    end

    assign enable   = enable_q;
    assign bit_tick = bit_tick_q;

endmodule

// File: tb/tb_baud_generator.sv
// Self-checking bench: four baud_generator configurations checked every cycle
// against an arithmetic model of edges-since-release, plus literal period checks.
`timescale 1ns/1ps
module tb_baud_generator;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_s;
    logic en_a, bt_a, en_b, bt_b, en_c, bt_c, en_d, bt_d;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t_a     = 0;
    int t_s     = 0;

    int rel[4];
    int last_en[4];
    int last_bt[4];
    int ens_between[4];
    logic prev_en[4];

    always #5 clk = ~clk;

    baud_generator #(.DIV(8), .OVERSAMPLE(16)) u_a (
        .clk(clk), .rst_n(rst_a), .enable(en_a), .bit_tick(bt_a));
    baud_generator #(.DIV(8), .OVERSAMPLE(4)) u_b (
        .clk(clk), .rst_n(rst_s), .enable(en_b), .bit_tick(bt_b));
    baud_generator u_c (
        .clk(clk), .rst_n(rst_s), .enable(en_c), .bit_tick(bt_c));
    baud_generator #(.DIV(2), .OVERSAMPLE(1)) u_d (
        .clk(clk), .rst_n(rst_s), .enable(en_d), .bit_tick(bt_d));

    always @(posedge clk) cyc <= cyc + 1;

    // Model time base: rising edges seen since each reset was released.
    always @(posedge clk or negedge rst_a) begin
        if (!rst_a) t_a <= 0;
        else        t_a <= t_a + 1;
    end

    always @(posedge clk or negedge rst_s) begin
        if (!rst_s) t_s <= 0;
        else        t_s <= t_s + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic mon(input int k, input logic en, input logic bt, input logic rst,
                       input int t, input int div, input int os);
        logic exp_en;
        logic exp_bt;
        exp_en = (t > 0) && (t % div == 0);
        exp_bt = (t > 0) && (t % (div * os) == 0);
        chk($sformatf("i%0d_enable_model", k), 32'(en), 32'(exp_en));
        chk($sformatf("i%0d_bit_tick_model", k), 32'(bt), 32'(exp_bt));
        chk($sformatf("i%0d_enable_width", k), 32'(en & prev_en[k]), 32'd0);
        if (!rst) begin
            last_en[k]     = -1;
            last_bt[k]     = -1;
            ens_between[k] = 0;
            prev_en[k]     = 1'b0;
        end else begin
            if (en === 1'b1) begin
                if (last_en[k] < 0) chk($sformatf("i%0d_first_enable", k), 32'(cyc - rel[k]), 32'(div));
                else                chk($sformatf("i%0d_enable_period", k), 32'(cyc - last_en[k]), 32'(div));
                last_en[k] = cyc;
            end
            if (bt === 1'b1) begin
                chk($sformatf("i%0d_bit_tick_coincident", k), 32'(en), 32'd1);
                if (last_bt[k] < 0) chk($sformatf("i%0d_first_bit_tick", k), 32'(cyc - rel[k]), 32'(div * os));
                else                chk($sformatf("i%0d_bit_tick_period", k), 32'(cyc - last_bt[k]), 32'(div * os));
                chk($sformatf("i%0d_enables_between", k), 32'(ens_between[k]), 32'(os - 1));
                last_bt[k]     = cyc;
                ens_between[k] = 0;
            end else if (en === 1'b1) begin
                ens_between[k]++;
            end
            prev_en[k] = en;
        end
    endtask

    // Per-cycle compare of every instance against the model, sampled mid-cycle.
    always @(negedge clk) begin
        mon(0, en_a, bt_a, rst_a, t_a, 8, 16);
        mon(1, en_b, bt_b, rst_s, t_s, 8, 4);
        mon(2, en_c, bt_c, rst_s, t_s, 54, 16);
        mon(3, en_d, bt_d, rst_s, t_s, 2, 1);
        chk("d_bit_tick_eq_enable", 32'(bt_d), 32'(en_d));
    end

    initial begin
        logic got;
        int   n;
        for (int i = 0; i < 4; i++) begin
            rel[i] = 0; last_en[i] = -1; last_bt[i] = -1; ens_between[i] = 0; prev_en[i] = 1'b0;
        end
        rst_a = 1'b0;
        rst_s = 1'b0;
        #1;
        chk("reset_enable_a", 32'(en_a), 32'd0);
        chk("reset_bit_tick_a", 32'(bt_a), 32'd0);

        repeat (3) @(posedge clk);
        #2;
        rst_a = 1'b1;
        rst_s = 1'b1;
        for (int i = 0; i < 4; i++) rel[i] = cyc;

        // Mid-period reset on instance a: five cycles after an enable, held two cycles.
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (en_a === 1'b1) begin got = 1'b1; break; end
        end
        chk("a_wait_enable", 32'(got), 32'd1);
        repeat (5) @(posedge clk);
        #3;
        rst_a = 1'b0;
        #1;
        chk("a_async_enable_zero", 32'(en_a), 32'd0);
        chk("a_async_bit_tick_zero", 32'(bt_a), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_a = 1'b1;
        rel[0] = cyc;

        // Long run: 1000 enable pulses on instance a while the others free-run.
        n = 0;
        for (int i = 0; i < 9000 && n < 1000; i++) begin
            @(negedge clk);
            if (en_a === 1'b1) n++;
        end
        chk("a_pulses_1000", 32'(n), 32'd1000);

        // Reset asserted while enable is high must clear it without waiting for a clock.
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (en_a === 1'b1) begin got = 1'b1; break; end
        end
        chk("a_wait_enable_end", 32'(got), 32'd1);
        #1;
        rst_a = 1'b0;
        #1;
        chk("a_async_clear_high", 32'(en_a), 32'd0);

        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (en_d === 1'b1 && bt_d === 1'b1) begin got = 1'b1; break; end
        end
        chk("d_wait_enable_end", 32'(got), 32'd1);
        #1;
        rst_s = 1'b0;
        #1;
        chk("d_async_clear_enable", 32'(en_d), 32'd0);
        chk("d_async_clear_bit_tick", 32'(bt_d), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
